// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared constants and reader state type for the 64 x 8 RAM and its burst reader
//
// Purpose: one place for the RAM geometry so the RAM and the reader agree.
// Contents: DATA_WIDTH, ADDR_WIDTH, DEPTH, reader_state_t.
package ram_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 6;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    SEND   = 2'd2,
    FINISH = 2'd3
  } reader_state_t;

endpackage

// File: rtl/ram_burst_reader.sv
// rtl/ram_burst_reader.sv - walks a RAM address range and streams bytes over VALID/READY
//
// Purpose: on START, reads LENGTH consecutive bytes (clamped to DEPTH, wrapping
// at the top of the RAM) from BASE_ADDR through the asynchronous read port and
// hands each one to a consumer with a VALID/READY handshake.
// Ports:
//   CLK, RST           clock, synchronous active-high reset
//   START              burst request, honoured only while idle
//   BASE_ADDR, LENGTH  burst first address and byte count, captured with START
//   RAM_ADDRESS        address to the RAM read port (registered)
//   RAM_DOUT           asynchronous RAM read data
//   DOUT, VALID, READY byte stream to the consumer
//   BUSY               high whenever a burst is in progress
//   DONE               one-cycle pulse after the last byte is accepted
module ram_burst_reader
  import ram_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [ADDR_WIDTH-1:0] BASE_ADDR,
  input  logic [ADDR_WIDTH:0]   LENGTH,
  output logic [ADDR_WIDTH-1:0] RAM_ADDRESS,
  input  logic [DATA_WIDTH-1:0] RAM_DOUT,
  output logic [DATA_WIDTH-1:0] DOUT,
  output logic                  VALID,
  input  logic                  READY,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   REM_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   REM_ZERO  = '0;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  reader_state_t         state, state_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic [ADDR_WIDTH:0]   rem, rem_n;      // bytes still to deliver, including the current one
  logic [DATA_WIDTH-1:0] dout_q, dout_n;
  logic                  valid_q, valid_n;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      addr    <= '0;
      rem     <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_n;
      addr    <= addr_n;
      rem     <= rem_n;
      dout_q  <= dout_n;
      valid_q <= valid_n;
    end
  end

  always_comb begin
    state_n = state;
    addr_n  = addr;
    rem_n   = rem;
    dout_n  = dout_q;
    valid_n = valid_q;
    case (state)
      IDLE: begin
        if (START && (LENGTH != REM_ZERO)) begin
          addr_n  = BASE_ADDR;
          rem_n   = (LENGTH > DEPTH_CNT) ? DEPTH_CNT : LENGTH;
          state_n = FETCH;
        end
      end
      FETCH: begin
        // RAM_ADDRESS has been stable for this whole cycle, so RAM_DOUT is settled.
        dout_n  = RAM_DOUT;
        valid_n = 1'b1;
        state_n = SEND;
      end
      SEND: begin
        if (valid_q && READY) begin
          valid_n = 1'b0;
          if (rem == REM_ONE) begin
            state_n = FINISH;
          end else begin
            rem_n   = rem - REM_ONE;
            addr_n  = addr + ADDR_ONE;  // natural wrap at the top of the RAM
            state_n = FETCH;
          end
        end
      end
      FINISH: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign RAM_ADDRESS = addr;
  assign DOUT        = dout_q;
  assign VALID       = valid_q;
  assign BUSY        = (state != IDLE);
  assign DONE        = (state == FINISH);

endmodule

// File: tb/tb_ram_burst_reader.sv
// tb/tb_ram_burst_reader.sv - self-checking bench for ram_burst_reader
module tb_ram_burst_reader;

  localparam int AW = ram_pkg::ADDR_WIDTH;
  localparam int DW = ram_pkg::DATA_WIDTH;
  localparam int DEP = ram_pkg::DEPTH;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_dout;
  logic [DW-1:0] dout;
  logic          valid;
  logic          ready;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [DEP];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign ram_dout = mem[ram_address];

  ram_burst_reader dut (
    .CLK        (clk),
    .RST        (rst),
    .START      (start),
    .BASE_ADDR  (base_addr),
    .LENGTH     (length),
    .RAM_ADDRESS(ram_address),
    .RAM_DOUT   (ram_dout),
    .DOUT       (dout),
    .VALID      (valid),
    .READY      (ready),
    .BUSY       (busy),
    .DONE       (done)
  );

  // Observations collected by do_burst; each test judges them itself.
  logic [DW-1:0] obs_bytes[$];
  int            obs_addr[$];
  int            obs_acc_cyc[$];
  int            obs_done_cnt;
  int            obs_done_gap;
  int            obs_first_valid;
  int            obs_unstable;
  int            obs_busy_at_done;
  int            obs_busy_after_done;
  int            obs_busy_seen;
  int            obs_timeout;

  // Reference: the bytes a burst must deliver, from the address rules alone.
  logic [DW-1:0] exp_bytes[$];
  int            exp_addr[$];

  task automatic build_expected(input int base, input int len);
    int n;
    exp_bytes.delete();
    exp_addr.delete();
    n = (len > DEP) ? DEP : len;
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back((base + i) % DEP);
      exp_bytes.push_back(mem[(base + i) % DEP]);
    end
  endtask

  // Called at a negedge with the reader idle; returns at a negedge.
  task automatic do_burst(input int base, input int len, input int ready_pct,
                          input int stall_first, input int mid_start, input int budget);
    int            cyc;
    int            last_acc;
    int            done_cyc;
    int            stalls;
    logic          prev_held;
    logic [DW-1:0] prev_dout;
    logic          acc;
    obs_bytes.delete();
    obs_addr.delete();
    obs_acc_cyc.delete();
    obs_done_cnt = 0; obs_done_gap = -1; obs_first_valid = -1; obs_unstable = 0;
    obs_busy_at_done = 0; obs_busy_after_done = 1; obs_busy_seen = 0; obs_timeout = 0;
    last_acc = -100; done_cyc = -1; stalls = 0; prev_held = 1'b0; prev_dout = '0;
    start = 1'b1; base_addr = AW'(base); length = (AW+1)'(len); ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (1) begin
      if (busy) obs_busy_seen = 1;
      if (done) begin
        obs_done_cnt++;
        obs_done_gap = cyc - last_acc;
        obs_busy_at_done = busy ? 1 : 0;
        done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) obs_busy_after_done = busy ? 1 : 0;
      if (prev_held && (!valid || dout !== prev_dout)) obs_unstable++;
      if (valid && obs_first_valid < 0) obs_first_valid = cyc;
      if (valid && obs_bytes.size() == 0 && stalls < stall_first) begin
        ready = 1'b0;
        stalls++;
      end else begin
        ready = ($urandom_range(99) < ready_pct);
      end
      acc = valid && ready;
      if (acc) begin
        obs_bytes.push_back(dout);
        obs_addr.push_back(int'(ram_address));
        obs_acc_cyc.push_back(cyc);
        last_acc = cyc;
      end
      prev_held = valid && !acc;
      prev_dout = dout;
      if (mid_start != 0 && cyc == 3) begin
        start = 1'b1; base_addr = AW'(10); length = (AW+1)'(5);
      end else begin
        start = 1'b0;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      if (cyc >= budget) begin
        if (len != 0 && done_cyc < 0) obs_timeout = 1;
        break;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    ready = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; base_addr = AW'(9); length = (AW+1)'(3); ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    n_tests++;
    if ({valid, busy, done} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: valid/busy/done=%b expected 000", {valid, busy, done});
    end
    n_tests++;
    if (dout !== '0 || ram_address !== '0) begin
      n_fail++; $display("FAIL reset_regs: dout=%h addr=%0d expected 00/0", dout, ram_address);
    end
  endtask

  task automatic test_basic;
    mem[5] = 8'h11; mem[6] = 8'h22; mem[7] = 8'h33; mem[8] = 8'h44;
    build_expected(5, 4);
    do_burst(5, 4, 100, 0, 0, 40);
    n_tests++;
    if (obs_bytes !== exp_bytes) begin
      n_fail++; $display("FAIL basic_bytes: got %p expected %p", obs_bytes, exp_bytes);
    end
    n_tests++;
    if (obs_first_valid !== 2) begin
      n_fail++; $display("FAIL basic_latency: first VALID at cycle %0d expected 2", obs_first_valid);
    end
    n_tests++;
    if (obs_acc_cyc.size() != 4 || obs_acc_cyc[1] - obs_acc_cyc[0] != 2 ||
        obs_acc_cyc[3] - obs_acc_cyc[2] != 2) begin
      n_fail++; $display("FAIL basic_throughput: accept cycles %p expected 2 apart", obs_acc_cyc);
    end
    n_tests++;
    if (obs_done_cnt != 1 || obs_done_gap != 1) begin
      n_fail++; $display("FAIL basic_done: count=%0d gap=%0d expected 1/1", obs_done_cnt, obs_done_gap);
    end
    n_tests++;
    if (obs_busy_at_done != 1 || obs_busy_after_done != 0) begin
      n_fail++; $display("FAIL basic_busy: at_done=%0d after=%0d expected 1/0",
                         obs_busy_at_done, obs_busy_after_done);
    end
  endtask

  task automatic test_wrap;
    mem[62] = 8'hAA; mem[63] = 8'hBB; mem[0] = 8'hCC;
    build_expected(62, 3);
    do_burst(62, 3, 100, 0, 0, 40);
    n_tests++;
    if (obs_bytes !== exp_bytes) begin
      n_fail++; $display("FAIL wrap_bytes: got %p expected %p", obs_bytes, exp_bytes);
    end
    n_tests++;
    if (obs_addr != exp_addr) begin
      n_fail++; $display("FAIL wrap_addr: got %p expected %p", obs_addr, exp_addr);
    end
  endtask

  task automatic test_backpressure;
    mem[0] = 8'h5A; mem[1] = 8'hA5;
    build_expected(0, 2);
    do_burst(0, 2, 100, 5, 0, 40);
    n_tests++;
    if (obs_bytes !== exp_bytes) begin
      n_fail++; $display("FAIL bp_bytes: got %p expected %p", obs_bytes, exp_bytes);
    end
    n_tests++;
    if (obs_unstable != 0) begin
      n_fail++; $display("FAIL bp_hold: %0d unstable cycles expected 0", obs_unstable);
    end
    n_tests++;
    if (obs_acc_cyc.size() != 2 || obs_acc_cyc[0] != 7 || obs_acc_cyc[1] != 9) begin
      n_fail++; $display("FAIL bp_timing: accept cycles %p expected 7,9", obs_acc_cyc);
    end
  endtask

  task automatic test_zero_len;
    do_burst(3, 0, 100, 0, 0, 10);
    n_tests++;
    if (obs_busy_seen != 0 || obs_first_valid != -1 || obs_done_cnt != 0) begin
      n_fail++; $display("FAIL zero_len: busy=%0d first_valid=%0d done=%0d expected 0/-1/0",
                         obs_busy_seen, obs_first_valid, obs_done_cnt);
    end
  endtask

  task automatic test_clamp;
    for (int i = 0; i < DEP; i++) mem[i] = DW'($urandom);
    build_expected(7, 100);
    do_burst(7, 100, 100, 0, 0, 200);
    n_tests++;
    if (obs_bytes.size() != 64 || obs_bytes !== exp_bytes) begin
      n_fail++; $display("FAIL clamp_bytes: got %0d bytes expected 64 (content match=%0d)",
                         obs_bytes.size(), obs_bytes == exp_bytes);
    end
    n_tests++;
    if (obs_done_cnt != 1 || obs_timeout != 0) begin
      n_fail++; $display("FAIL clamp_done: count=%0d timeout=%0d expected 1/0", obs_done_cnt, obs_timeout);
    end
  endtask

  task automatic test_start_busy;
    for (int i = 0; i < DEP; i++) mem[i] = DW'($urandom);
    build_expected(40, 6);
    do_burst(40, 6, 100, 0, 1, 60);
    n_tests++;
    if (obs_bytes !== exp_bytes || obs_addr != exp_addr) begin
      n_fail++; $display("FAIL start_busy: got %p expected %p", obs_bytes, exp_bytes);
    end
    n_tests++;
    if (obs_done_cnt != 1 || obs_busy_after_done != 0) begin
      n_fail++; $display("FAIL start_busy_done: count=%0d busy_after=%0d expected 1/0",
                         obs_done_cnt, obs_busy_after_done);
    end
  endtask

  task automatic test_rst_mid;
    int cyc;
    int saw_done;
    start = 1'b1; base_addr = AW'(20); length = (AW+1)'(8); ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!valid && cyc < 10) begin
      @(posedge clk); @(negedge clk); cyc++;
    end
    n_tests++;
    if (!valid) begin
      n_fail++; $display("FAIL rst_mid_setup: VALID never rose, got %b expected 1", valid);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if ({valid, busy, done} !== 3'b000 || dout !== '0 || ram_address !== '0) begin
      n_fail++; $display("FAIL rst_mid: v/b/d=%b dout=%h addr=%0d expected 000/00/0",
                         {valid, busy, done}, dout, ram_address);
    end
    saw_done = 0;
    repeat (6) begin
      @(posedge clk); @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    n_tests++;
    if (saw_done != 0) begin
      n_fail++; $display("FAIL rst_mid_quiet: DONE/BUSY activity=%0d expected 0", saw_done);
    end
    build_expected(33, 3);
    do_burst(33, 3, 100, 0, 0, 40);
    n_tests++;
    if (obs_bytes !== exp_bytes || obs_done_cnt != 1) begin
      n_fail++; $display("FAIL rst_mid_restart: got %p done=%0d expected %p done=1",
                         obs_bytes, obs_done_cnt, exp_bytes);
    end
  endtask

  task automatic test_random;
    int base;
    int len;
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 8; i++) mem[$urandom_range(DEP - 1)] = DW'($urandom);
      base = $urandom_range(DEP - 1);
      len  = $urandom_range(1, 80);
      build_expected(base, len);
      do_burst(base, len, 60, 0, 0, 1000);
      n_tests++;
      if (obs_bytes !== exp_bytes || obs_addr != exp_addr) begin
        n_fail++; $display("FAIL random_%0d: base=%0d len=%0d got %0d bytes expected %0d",
                           k, base, len, obs_bytes.size(), exp_bytes.size());
      end
      n_tests++;
      if (obs_done_cnt != 1 || obs_done_gap != 1 || obs_unstable != 0 || obs_timeout != 0) begin
        n_fail++; $display("FAIL random_%0d_hs: done=%0d gap=%0d unstable=%0d timeout=%0d expected 1/1/0/0",
                           k, obs_done_cnt, obs_done_gap, obs_unstable, obs_timeout);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEP; i++) mem[i] = DW'(i * 3);
    @(negedge clk);
    test_reset;
    test_basic;
    test_wrap;
    test_backpressure;
    test_zero_len;
    test_clamp;
    test_start_busy;
    test_rst_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
